// File: rtl/alu_arbiter_pkg.sv
// Shared ALU types: operand width, command encoding, task and response records.
// The EX stage and the arbiter both build on these definitions.
package alu;

    localparam int DATA_WIDTH = 16;
    localparam int TAG_WIDTH  = 3;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4
    } alu_cmd_t;

    typedef struct packed {
        alu_cmd_t              cmd;
        logic [DATA_WIDTH-1:0] a;
        logic [DATA_WIDTH-1:0] b;
    } alu_task_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [TAG_WIDTH-1:0]  tag;
        logic                  owner;
    } alu_rsp_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Two-requester ALU bus: request handshakes in, one shared result register out.
// slave is the arbiter side, master is the requester side.
interface alu_arbiter_if #(
    parameter int DATA_WIDTH = alu::DATA_WIDTH,
    parameter int TAG_W      = 3
) ();

    logic                  req0_valid_i;
    logic                  req1_valid_i;
    logic                  req0_ready_o;
    logic                  req1_ready_o;
    alu::alu_task_t        req0_task_i;
    alu::alu_task_t        req1_task_i;
    logic [TAG_W-1:0]      req0_tag_i;
    logic [TAG_W-1:0]      req1_tag_i;
    logic                  rsp0_valid_o;
    logic                  rsp1_valid_o;
    logic                  rsp0_ready_i;
    logic                  rsp1_ready_i;
    logic [DATA_WIDTH-1:0] rsp_data_o;
    logic [TAG_W-1:0]      rsp_tag_o;
    logic                  busy_o;

    modport slave (
        input  req0_valid_i, req1_valid_i, req0_task_i, req1_task_i,
        input  req0_tag_i, req1_tag_i, rsp0_ready_i, rsp1_ready_i,
        output req0_ready_o, req1_ready_o, rsp0_valid_o, rsp1_valid_o,
        output rsp_data_o, rsp_tag_o, busy_o
    );

    modport master (
        output req0_valid_i, req1_valid_i, req0_task_i, req1_task_i,
        output req0_tag_i, req1_tag_i, rsp0_ready_i, rsp1_ready_i,
        input  req0_ready_o, req1_ready_o, rsp0_valid_o, rsp1_valid_o,
        input  rsp_data_o, rsp_tag_o, busy_o
    );

endinterface

// File: rtl/alu_arbiter_core.sv
// Combinational ALU: modular add/sub and bitwise ops, no flags.
// Unknown command encodings produce zero rather than an error.
module alu_core
    import alu::*;
(
    input  alu_task_t             task_i,
    output logic [DATA_WIDTH-1:0] result_o
);

    always_comb begin
        result_o = '0;
        case (task_i.cmd)
            ALU_ADD: result_o = task_i.a + task_i.b;
            ALU_SUB: result_o = task_i.a - task_i.b;
            ALU_AND: result_o = task_i.a & task_i.b;
            ALU_OR:  result_o = task_i.a | task_i.b;
            ALU_XOR: result_o = task_i.a ^ task_i.b;
            default: result_o = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin share of one ALU between two requesters, with a one-entry
// result register that can drain and refill in the same cycle.
module alu_arbiter
    import alu::alu_task_t;
#(
    parameter int DATA_WIDTH = alu::DATA_WIDTH,
    parameter int TAG_W      = 3
) (
    input logic          clk_i,
    input logic          rst_i,
    alu_arbiter_if.slave bus
);

    logic                  full_q, full_d;
    logic                  owner_q, owner_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [TAG_W-1:0]      tag_q, tag_d;
    logic                  last_grant_q, last_grant_d;

    logic [1:0]                 req_valid;
    logic [1:0]                 req_ready;
    logic [1:0]                 rsp_valid;
    logic [1:0]                 rsp_ready;
    logic [1:0]                 grant;
    logic                       drain;
    logic                       can_accept;
    logic                       accept;
    alu_task_t                  sel_task;
    logic [TAG_W-1:0]           sel_tag;
    logic [alu::DATA_WIDTH-1:0] core_result;

    assign req_valid = {bus.req1_valid_i, bus.req0_valid_i};
    assign rsp_ready = {bus.rsp1_ready_i, bus.rsp0_ready_i};

    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        assign rsp_valid[gi] = full_q && (owner_q == 1'(gi));
    end

    // last_grant_q == 1 means port 1 went last, so port 0 wins a tie.
    always_comb begin
        grant = 2'b00;
        if (req_valid[0] && (!req_valid[1] || last_grant_q)) begin
            grant = 2'b01;
        end else if (req_valid[1]) begin
            grant = 2'b10;
        end
    end

    assign drain      = |(rsp_valid & rsp_ready);
    assign can_accept = !full_q || drain;
    assign req_ready  = grant & {2{can_accept}};
    assign accept     = |(req_valid & req_ready);

    assign sel_task = grant[1] ? bus.req1_task_i : bus.req0_task_i;
    assign sel_tag  = grant[1] ? bus.req1_tag_i  : bus.req0_tag_i;

    alu_core u_core (
        .task_i   (sel_task),
        .result_o (core_result)
    );

    always_comb begin
        full_d       = full_q;
        owner_d      = owner_q;
        data_d       = data_q;
        tag_d        = tag_q;
        last_grant_d = last_grant_q;
        if (accept) begin
            full_d       = 1'b1;
            owner_d      = grant[1];
            data_d       = DATA_WIDTH'(core_result);
            tag_d        = sel_tag;
            last_grant_d = grant[1];
        end else if (drain) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            full_q       <= 1'b0;
            owner_q      <= 1'b0;
            data_q       <= '0;
            tag_q        <= '0;
            last_grant_q <= 1'b1;
        end else begin
            full_q       <= full_d;
            owner_q      <= owner_d;
            data_q       <= data_d;
            tag_q        <= tag_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign bus.req0_ready_o = req_ready[0];
    assign bus.req1_ready_o = req_ready[1];
    assign bus.rsp0_valid_o = rsp_valid[0];
    assign bus.rsp1_valid_o = rsp_valid[1];
    assign bus.rsp_data_o   = data_q;
    assign bus.rsp_tag_o    = tag_q;
    assign bus.busy_o       = full_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed and randomized checks of alu_arbiter: handshakes, fairness,
// backpressure, reset and an in-order scoreboard against a reference ALU.
module tb_alu_arbiter;
    import alu::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    alu_arbiter_if #(.DATA_WIDTH(16), .TAG_W(3)) bus ();

    alu_arbiter #(.DATA_WIDTH(16), .TAG_W(3)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    typedef struct packed {
        logic        owner;
        logic [2:0]  tag;
        logic [15:0] data;
    } exp_t;

    exp_t      sb_q[$];
    logic      p_valid[2];
    alu_task_t p_task[2];
    logic [2:0] p_tag[2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [15:0] ref_alu(input logic [2:0] cmd, input logic [15:0] a,
                                            input logic [15:0] b);
        case (cmd)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            default: return 16'h0000;
        endcase
    endfunction

    initial begin
        bus.req0_valid_i = 0; bus.req1_valid_i = 0;
        bus.req0_task_i = '0; bus.req1_task_i = '0;
        bus.req0_tag_i = '0;  bus.req1_tag_i = '0;
        bus.rsp0_ready_i = 0; bus.rsp1_ready_i = 0;

        // reset state
        tick(); tick();
        chk("rst_rsp0_valid", 32'(bus.rsp0_valid_o), 0);
        chk("rst_rsp1_valid", 32'(bus.rsp1_valid_o), 0);
        chk("rst_busy", 32'(bus.busy_o), 0);
        chk("rst_data", 32'(bus.rsp_data_o), 0);
        chk("rst_tag", 32'(bus.rsp_tag_o), 0);
        chk("rst_req0_ready", 32'(bus.req0_ready_o), 0);
        rst = 0;
        tick();

        // single ADD on port 0
        bus.req0_valid_i = 1; bus.req0_task_i = '{cmd: ALU_ADD, a: 16'h0003, b: 16'h0004};
        bus.req0_tag_i = 3'd5; bus.rsp0_ready_i = 1;
        #1 chk("add_req0_ready", 32'(bus.req0_ready_o), 1);
        chk("add_req1_ready", 32'(bus.req1_ready_o), 0);
        tick();
        bus.req0_valid_i = 0;
        #1 chk("add_rsp0_valid", 32'(bus.rsp0_valid_o), 1);
        chk("add_data", 32'(bus.rsp_data_o), 32'h0007);
        chk("add_tag", 32'(bus.rsp_tag_o), 5);
        chk("add_rsp1_valid", 32'(bus.rsp1_valid_o), 0);
        chk("add_busy", 32'(bus.busy_o), 1);
        tick();
        chk("add_drained", 32'(bus.busy_o), 0);

        // undefined command on port 1
        bus.req1_valid_i = 1; bus.req1_task_i = '{cmd: alu_cmd_t'(3'd7), a: 16'hAAAA, b: 16'h5555};
        bus.req1_tag_i = 3'd6; bus.rsp1_ready_i = 1;
        #1 chk("undef_req1_ready", 32'(bus.req1_ready_o), 1);
        tick();
        bus.req1_valid_i = 0;
        #1 chk("undef_rsp1_valid", 32'(bus.rsp1_valid_o), 1);
        chk("undef_data", 32'(bus.rsp_data_o), 32'h0000);
        chk("undef_tag", 32'(bus.rsp_tag_o), 6);
        tick();

        // continuous contention, port 1 went last
        bus.req0_valid_i = 1; bus.req0_task_i = '{cmd: ALU_SUB, a: 16'h0000, b: 16'h0001};
        bus.req0_tag_i = 3'd1;
        bus.req1_valid_i = 1; bus.req1_task_i = '{cmd: ALU_XOR, a: 16'hFF00, b: 16'h0FF0};
        bus.req1_tag_i = 3'd2;
        for (int i = 0; i < 4; i++) begin
            #1 chk($sformatf("rr%0d_req0_ready", i), 32'(bus.req0_ready_o), 32'(i % 2 == 0));
            chk($sformatf("rr%0d_req1_ready", i), 32'(bus.req1_ready_o), 32'(i % 2 == 1));
            if (i > 0) begin
                if ((i - 1) % 2 == 0) begin
                    chk($sformatf("rr%0d_rsp0_valid", i), 32'(bus.rsp0_valid_o), 1);
                    chk($sformatf("rr%0d_data", i), 32'(bus.rsp_data_o), 32'hFFFF);
                end else begin
                    chk($sformatf("rr%0d_rsp1_valid", i), 32'(bus.rsp1_valid_o), 1);
                    chk($sformatf("rr%0d_data", i), 32'(bus.rsp_data_o), 32'hF0F0);
                end
            end
            tick();
        end
        bus.req0_valid_i = 0; bus.req1_valid_i = 0;
        #1 chk("rr_last_rsp1_valid", 32'(bus.rsp1_valid_o), 1);
        chk("rr_last_data", 32'(bus.rsp_data_o), 32'hF0F0);
        chk("rr_last_tag", 32'(bus.rsp_tag_o), 2);
        tick();

        // backpressure from port 1 blocks port 0
        bus.rsp1_ready_i = 0;
        bus.req1_valid_i = 1; bus.req1_task_i = '{cmd: ALU_AND, a: 16'h1234, b: 16'h00FF};
        bus.req1_tag_i = 3'd3;
        #1 chk("bp_req1_ready", 32'(bus.req1_ready_o), 1);
        tick();
        bus.req1_valid_i = 0;
        bus.req0_valid_i = 1; bus.req0_task_i = '{cmd: ALU_ADD, a: 16'h0001, b: 16'h0001};
        bus.req0_tag_i = 3'd4;
        for (int k = 0; k < 3; k++) begin
            #1 chk($sformatf("bp%0d_req0_ready", k), 32'(bus.req0_ready_o), 0);
            chk($sformatf("bp%0d_rsp1_valid", k), 32'(bus.rsp1_valid_o), 1);
            chk($sformatf("bp%0d_data", k), 32'(bus.rsp_data_o), 32'h0034);
            chk($sformatf("bp%0d_tag", k), 32'(bus.rsp_tag_o), 3);
            tick();
        end
        bus.rsp1_ready_i = 1;
        #1 chk("bp_release_req0_ready", 32'(bus.req0_ready_o), 1);
        tick();
        bus.req0_valid_i = 0;
        #1 chk("bp_rsp0_valid", 32'(bus.rsp0_valid_o), 1);
        chk("bp_rsp0_data", 32'(bus.rsp_data_o), 32'h0002);
        chk("bp_rsp0_tag", 32'(bus.rsp_tag_o), 4);
        chk("bp_rsp1_valid", 32'(bus.rsp1_valid_o), 0);
        tick();

        // reset while a result is pending; port 0 went last before reset
        bus.rsp0_ready_i = 0;
        bus.req0_valid_i = 1; bus.req0_task_i = '{cmd: ALU_OR, a: 16'h00F0, b: 16'h0F00};
        bus.req0_tag_i = 3'd7;
        #1 chk("rs_req0_ready", 32'(bus.req0_ready_o), 1);
        tick();
        bus.req0_valid_i = 0;
        #1 chk("rs_rsp0_valid", 32'(bus.rsp0_valid_o), 1);
        chk("rs_data", 32'(bus.rsp_data_o), 32'h0FF0);
        bus.req1_valid_i = 1; bus.req1_task_i = '{cmd: ALU_ADD, a: 16'h0007, b: 16'h0008};
        bus.req1_tag_i = 3'd2;
        rst = 1;
        tick();
        rst = 0;
        bus.req0_valid_i = 1; bus.req0_task_i = '{cmd: ALU_ADD, a: 16'h0005, b: 16'h0006};
        bus.req0_tag_i = 3'd1;
        bus.rsp0_ready_i = 1; bus.rsp1_ready_i = 1;
        #1 chk("rs_after_rsp0_valid", 32'(bus.rsp0_valid_o), 0);
        chk("rs_after_rsp1_valid", 32'(bus.rsp1_valid_o), 0);
        chk("rs_after_busy", 32'(bus.busy_o), 0);
        chk("rs_first_req0_ready", 32'(bus.req0_ready_o), 1);
        chk("rs_first_req1_ready", 32'(bus.req1_ready_o), 0);
        tick();
        bus.req0_valid_i = 0;
        #1 chk("rs_p0_rsp0_valid", 32'(bus.rsp0_valid_o), 1);
        chk("rs_p0_data", 32'(bus.rsp_data_o), 32'h000B);
        chk("rs_p0_tag", 32'(bus.rsp_tag_o), 1);
        chk("rs_p1_req1_ready", 32'(bus.req1_ready_o), 1);
        tick();
        bus.req1_valid_i = 0;
        #1 chk("rs_p1_rsp1_valid", 32'(bus.rsp1_valid_o), 1);
        chk("rs_p1_data", 32'(bus.rsp_data_o), 32'h000F);
        chk("rs_p1_tag", 32'(bus.rsp_tag_o), 2);
        tick();

        // random traffic with in-order scoreboard
        p_valid[0] = 0; p_valid[1] = 0;
        for (int cyc = 0; cyc < 420; cyc++) begin
            for (int p = 0; p < 2; p++) begin
                if (cyc < 400 && !p_valid[p] && $urandom_range(0, 99) < 60) begin
                    p_valid[p] = 1;
                    p_task[p].cmd = alu_cmd_t'(3'($urandom_range(0, 7)));
                    p_task[p].a = 16'($urandom);
                    p_task[p].b = 16'($urandom);
                    p_tag[p] = 3'($urandom_range(0, 7));
                end
            end
            bus.req0_valid_i = p_valid[0]; bus.req0_task_i = p_task[0]; bus.req0_tag_i = p_tag[0];
            bus.req1_valid_i = p_valid[1]; bus.req1_task_i = p_task[1]; bus.req1_tag_i = p_tag[1];
            bus.rsp0_ready_i = (cyc >= 400) || ($urandom_range(0, 99) < 70);
            bus.rsp1_ready_i = (cyc >= 400) || ($urandom_range(0, 99) < 70);
            #1;
            if (bus.req0_ready_o && bus.req1_ready_o) chk("rnd_one_grant", 1, 0);
            if ((bus.rsp0_valid_o && bus.rsp0_ready_i) || (bus.rsp1_valid_o && bus.rsp1_ready_i)) begin
                if (sb_q.size() == 0) begin
                    chk("rnd_unexpected_rsp", 1, 0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk("rnd_rsp", 32'({bus.rsp1_valid_o, bus.rsp_tag_o, bus.rsp_data_o}), 32'(e));
                    $display("[TB] rsp port=%0d tag=%0d data=0x%04h", e.owner, e.tag, e.data);
                end
            end
            for (int p = 0; p < 2; p++) begin
                logic acc;
                acc = (p == 0) ? (bus.req0_valid_i && bus.req0_ready_o)
                               : (bus.req1_valid_i && bus.req1_ready_o);
                if (acc) begin
                    sb_q.push_back('{owner: 1'(p), tag: p_tag[p],
                                     data: ref_alu(p_task[p].cmd, p_task[p].a, p_task[p].b)});
                    p_valid[p] = 0;
                end
            end
            tick();
        end
        chk("rnd_all_drained", 32'(sb_q.size()), 0);
        chk("rnd_end_busy", 32'(bus.busy_o), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one ALU datapath between two requesters: the pipeline EX stage (port 0) and an auxiliary unit such as a debug or address-generation engine (port 1). Each requester hands over an `alu_task_t` and a tag through a valid/ready handshake. The block arbitrates round-robin, computes the result, and returns it to the owning requester from a one-entry result register with its own valid/ready handshake. It sits between the decode/issue logic and the MEM stage, in place of a private per-stage ALU.

## Interface
- `DATA_WIDTH`, default `alu::DATA_WIDTH` (16): operand/result width.
- `TAG_W`, default 3: width of the requester-opaque tag returned with the result.

- `clk_i` input 1: clock, all state updates on rising edge.
- `rst_i` input 1: reset, synchronous, active-high.
- `req0_valid_i` / `req1_valid_i` input 1: request present.
- `req0_ready_o` / `req1_ready_o` output 1: request accepted this cycle when high together with valid.
- `req0_task_i` / `req1_task_i` input `alu_task_t`: `cmd`, `a`, `b`.
- `req0_tag_i` / `req1_tag_i` input `TAG_W`: tag echoed on the response.
- `rsp0_valid_o` / `rsp1_valid_o` output 1: result for that requester is held in the result register.
- `rsp0_ready_i` / `rsp1_ready_i` input 1: requester consumes the result.
- `rsp_data_o` output `DATA_WIDTH`: result, shared by both response ports.
- `rsp_tag_o` output `TAG_W`: tag of the result, shared by both response ports.
- `busy_o` output 1: result register occupied.

## Operation
- Handshake rules:
  - Requesters hold valid, task and tag stable until ready.
  - `ready_o` may depend combinationally on `valid_i`; `valid_i` must not depend on `ready_o`.
- Arbitration:
  - Exactly one requester can be granted per cycle.
  - When both are valid, the requester not granted last wins.
  - When one is valid, it wins.
  - The `last_grant` pointer updates only on an accepted transfer (valid&&ready).
- Accept condition: `can_accept = !full || (rsp_valid_owner && rsp_ready_owner)`.
  - `reqX_ready_o = grantX && can_accept`.
  - A non-granted requester sees ready = 0.
- Result register contents: `full`, `owner` (1 bit), `data`, `tag`.
  - Loaded on accept with the ALU result of the granted task.
  - Cleared on drain when no new accept happens in the same cycle.
  - Drain and accept in the same cycle: the register is overwritten and `full` stays 1.
- ALU function (combinational, `DATA_WIDTH` modular arithmetic, no carry/flags):
  - `ALU_ADD` = a+b
  - `ALU_SUB` = a−b (wraps, e.g. 0x0000−0x0001 = 0xFFFF)
  - `ALU_AND`, `ALU_OR`, `ALU_XOR` = bitwise
  - any other cmd = 0, which is still returned normally.
- Response routing:
  - `rspX_valid_o = full && owner==X`.
  - `rsp_data_o` and `rsp_tag_o` are valid only while some `rspX_valid_o` is high.
- Reset values:
  - All outputs 0.
  - `full` = 0.
  - `last_grant` = 1, so port 0 has priority on the first contention after reset.
  - Reset during an occupied result drops the pending result and any in-flight acceptance.

## Timing
- Latency: request accepted at edge N; `rspX_valid_o` is high after edge N (visible in cycle N+1).
- Throughput: one result per cycle when the owner holds `rsp_ready_i` = 1.
- Backpressure: while the owner holds `rsp_ready_i` = 0, both `req*_ready_o` stay 0 and the result and tag hold stable.
- Combinational paths: `rsp*_ready_i` → `req*_ready_o` and `req*_valid_i` → `req*_ready_o`. There is no combinational path to `rsp*` outputs.
- Fairness: under continuous contention with no backpressure, grants alternate 0,1,0,1…; neither port waits more than one accepted transfer.

## Structure
- The `alu` package already holds `DATA_WIDTH`, `alu_cmd_t` (`ALU_ADD`…`ALU_XOR`) and `alu_task_t`.
- Add to the `alu` package an `alu_rsp_t` struct: `data`, `tag`, `owner`.
- Sub-module `alu_core`: purely combinational `alu_task_t` → result. It is reused by the EX stage so both share one ALU definition.
- The arbiter holds only the grant logic, the `last_grant` flop and the result register.

## Test plan
- Reset, then req0 {ADD, 0x0003, 0x0004, tag 5}, rsp0_ready=1 → req0_ready=1 in the same cycle; next cycle rsp0_valid=1, data 0x0007, tag 5, rsp1_valid=0.
- Both valid continuously for 4 cycles (req0 SUB 0x0000−0x0001, req1 XOR 0xFF00^0x0FF0), both rsp_ready=1 → grants 0,1,0,1; results alternate 0xFFFF (rsp0) and 0xF0F0 (rsp1), one per cycle.
- req1 AND 0x1234&0x00FF accepted, rsp1_ready=0 for 3 cycles while req0 stays valid → req0_ready=0 and rsp_data_o=0x0034 stable throughout; on the cycle rsp1_ready=1, req0 is accepted in that same cycle.
- Undefined cmd encoding with a=0xAAAA, b=0x5555 → response returned with data 0x0000 and the correct tag.
- rst_i asserted for one cycle while rsp0_valid=1 → next cycle all rsp valids and `busy_o` are 0; the first contention afterwards grants port 0.
- Random valid/ready with a scoreboard keyed by port and tag → every accepted request yields exactly one response, in order, with data matching a reference ALU model.
